// File: rtl/lap_timer_multi_if.sv
// Bundles the race controls and per-player timing results between a driver and the lap timer.
// Widths follow PLAYERS/WIDTH; every field is a level signal sampled on the shared clock.
interface lap_timer_multi_if #(
    parameter int PLAYERS = 2,
    parameter int WIDTH   = 16
);
    logic                       tick;
    logic                       race_start;
    logic [PLAYERS-1:0]         lap_finished;
    logic [PLAYERS*WIDTH-1:0]   current_lap_time;
    logic [PLAYERS*WIDTH-1:0]   last_lap_time;
    logic [PLAYERS*WIDTH-1:0]   best_lap_time;
    logic [PLAYERS-1:0]         best_valid;
    logic [PLAYERS*4-1:0]       lap_count;
    logic [PLAYERS-1:0]         player_done;
    logic [2:0]                 winner;
    logic                       winner_valid;
    logic                       race_done;

    modport master (
        output tick, race_start, lap_finished,
        input  current_lap_time, last_lap_time, best_lap_time, best_valid,
               lap_count, player_done, winner, winner_valid, race_done
    );

    modport slave (
        input  tick, race_start, lap_finished,
        output current_lap_time, last_lap_time, best_lap_time, best_valid,
               lap_count, player_done, winner, winner_valid, race_done
    );
endinterface

// File: rtl/lap_timer_multi.sv
// Multi-player lap timer: per-player running/last/best lap times, lap counts and first-finisher detection.
// All outputs registered, 1-cycle latency from lap_finished; no backpressure, inputs are single-cycle pulses.
module lap_timer_multi #(
    parameter int PLAYERS = 2,
    parameter int WIDTH   = 16,
    parameter int LAPS    = 3,
    parameter int MIN_LAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    lap_timer_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RACING, FINISHED} state_t;

    localparam logic [WIDTH-1:0] SAT_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(MIN_LAP);
    localparam logic [3:0]       LAPS_VAL = 4'(LAPS);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_q  [PLAYERS];
    logic [WIDTH-1:0]   cur_d  [PLAYERS];
    logic [WIDTH-1:0]   last_q [PLAYERS];
    logic [WIDTH-1:0]   last_d [PLAYERS];
    logic [WIDTH-1:0]   best_q [PLAYERS];
    logic [WIDTH-1:0]   best_d [PLAYERS];
    logic [3:0]         cnt_q  [PLAYERS];
    logic [3:0]         cnt_d  [PLAYERS];
    logic [PLAYERS-1:0] bv_q, bv_d;
    logic [PLAYERS-1:0] done_q, done_d;
    logic [2:0]         win_q, win_d;
    logic               wv_q, wv_d;
    logic               won;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int p = 0; p < PLAYERS; p++) begin
                cur_q[p]  <= '0;
                last_q[p] <= '0;
                best_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
            bv_q   <= '0;
            done_q <= '0;
            win_q  <= '0;
            wv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            best_q  <= best_d;
            cnt_q   <= cnt_d;
            bv_q    <= bv_d;
            done_q  <= done_d;
            win_q   <= win_d;
            wv_q    <= wv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        best_d  = best_q;
        cnt_d   = cnt_q;
        bv_d    = bv_q;
        done_d  = done_q;
        win_d   = win_q;
        wv_d    = wv_q;
        won     = 1'b0;

        if (bus.race_start) begin
            state_d = RACING;
            for (int p = 0; p < PLAYERS; p++) begin
                cur_d[p]  = '0;
                last_d[p] = '0;
                best_d[p] = '0;
                cnt_d[p]  = '0;
            end
            bv_d   = '0;
            done_d = '0;
            win_d  = '0;
            wv_d   = 1'b0;
        end else if (state_q == RACING) begin
            if (&done_q) begin
                state_d = FINISHED;
            end
            // Ascending scan so the lowest-index simultaneous finisher claims the win.
            for (int p = 0; p < PLAYERS; p++) begin
                if (!done_q[p]) begin
                    if (bus.lap_finished[p] && (cur_q[p] >= MIN_VAL)) begin
                        last_d[p] = cur_q[p];
                        cur_d[p]  = '0;
                        cnt_d[p]  = cnt_q[p] + 4'd1;
                        bv_d[p]   = 1'b1;
                        if (!bv_q[p] || (cur_q[p] < best_q[p])) begin
                            best_d[p] = cur_q[p];
                        end
                        if ((cnt_q[p] + 4'd1) == LAPS_VAL) begin
                            done_d[p] = 1'b1;
                            if (!wv_q && !won) begin
                                won   = 1'b1;
                                win_d = 3'(p);
                                wv_d  = 1'b1;
                            end
                        end
                    end else if (bus.tick && (cur_q[p] != SAT_VAL)) begin
                        cur_d[p] = cur_q[p] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < PLAYERS; g++) begin : g_pack
        assign bus.current_lap_time[g*WIDTH +: WIDTH] = cur_q[g];
        assign bus.last_lap_time[g*WIDTH +: WIDTH]    = last_q[g];
        assign bus.best_lap_time[g*WIDTH +: WIDTH]    = best_q[g];
        assign bus.lap_count[g*4 +: 4]                = cnt_q[g];
    end

    assign bus.best_valid   = bv_q;
    assign bus.player_done  = done_q;
    assign bus.winner       = win_q;
    assign bus.winner_valid = wv_q;
    assign bus.race_done    = (state_q == FINISHED);
endmodule

// File: doc/lap_timer_multi.md
LAP_TIMER_MULTI -- requirements
Module: lap_timer_multi

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide PLAYERS, 2: number of independent timing channels (1..8).
REQ-002 SHALL provide WIDTH, 16: bit width of every lap-time value.
REQ-003 SHALL provide LAPS, 3: laps per race (1..15).
REQ-004 SHALL provide MIN_LAP, 4: minimum accepted lap time in ticks (debounce).

Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have tick, input, 1: one-cycle time-base pulse; one tick equals one time unit.
REQ-008 SHALL have race_start, input, 1: one-cycle pulse that clears all channels and starts a race.
REQ-009 SHALL have lap_finished, input, PLAYERS: per-player finish-line pulse.
REQ-010 SHALL have current_lap_time, output, PLAYERS*WIDTH: running lap time; player p occupies bits [p*WIDTH +: WIDTH].
REQ-011 SHALL have last_lap_time, output, PLAYERS*WIDTH: last completed lap time, same packing.
REQ-012 SHALL have best_lap_time, output, PLAYERS*WIDTH: best completed lap time, same packing.
REQ-013 SHALL have best_valid, output, PLAYERS: set once player p has a best lap.
REQ-014 SHALL have lap_count, output, PLAYERS*4: completed laps per player, 4 bits each.
REQ-015 SHALL have player_done, output, PLAYERS: player p has completed LAPS laps.
REQ-016 SHALL have winner, output, 3: index of the first player to finish.
REQ-017 SHALL have winner_valid, output, 1: winner holds a valid index.
REQ-018 SHALL have race_done, output, 1: high in FINISHED.

Function
REQ-019 SHALL implement states IDLE, RACING and FINISHED.
REQ-020 SHALL transition IDLE->RACING on race_start.
REQ-021 SHALL transition RACING->FINISHED in the cycle after all player_done bits are 1.
REQ-022 SHALL restart on race_start in any state: next cycle is RACING with all per-player registers, winner and winner_valid cleared.
REQ-023 SHALL ignore tick and lap_finished in IDLE and FINISHED; all outputs hold.
REQ-024 In RACING, for each player not done, SHALL increment current_lap_time by 1 per tick, saturating at 2^WIDTH-1.
REQ-025 SHALL accept lap_finished[p] only when in RACING, player_done[p]=0 and current_lap_time[p] >= MIN_LAP; otherwise the pulse is ignored with no state change.
REQ-026 On accepted lap: next cycle last_lap_time[p] = pre-edge current_lap_time[p], current_lap_time[p] = 0 (a coincident tick is discarded), lap_count[p] += 1.
REQ-027 On accepted lap: best_lap_time[p] SHALL update to the captured time in the same edge if best_valid[p]=0 or the captured time < best_lap_time[p]; best_valid[p] is set. Ties SHALL NOT update.
REQ-028 When an accepted lap makes lap_count[p]=LAPS, player_done[p] SHALL set in the same edge, and current_lap_time[p] SHALL freeze at 0.
REQ-029 The first edge setting any player_done while winner_valid=0 SHALL load winner and set winner_valid; on simultaneous finishes the lowest index wins.
REQ-030 Channels SHALL be fully independent; simultaneous lap_finished on several players are each handled per REQ-025..029.
REQ-031 All outputs SHALL be registered; lap-related latency is 1 cycle from lap_finished.

Reset
REQ-032 rst SHALL take priority over race_start and all other inputs.
REQ-033 On rst, state SHALL become IDLE and every output SHALL be 0, including best_valid, winner_valid and race_done.
REQ-034 Asserting rst mid-race SHALL abort the race with no partial update in that cycle.

Verification
REQ-035 PLAYERS=2, MIN_LAP=4: start, 10 ticks, lap_finished[0] -> last[0]=10, best[0]=10, best_valid[0]=1, lap_count[0]=1, current[0]=0.
REQ-036 Laps of 10 then 12 then 7 ticks on p0 -> best[0] sequence 10, 10, 7; lap 3 sets player_done[0], winner=0, winner_valid=1.
REQ-037 lap_finished[1] at current[1]=3 -> ignored; with tick in the same cycle, current[1] becomes 4 and lap_count[1] stays 0.
REQ-038 Both players finish their final lap in the same cycle -> winner=0, race_done=1 one cycle later, and subsequent ticks cause no change.
REQ-039 WIDTH=4, 20 ticks with no lap -> current saturates at 15; rst mid-race -> all outputs 0, IDLE; race_start together with rst -> remains IDLE.
